// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psram_pkg
// Description : Shared constants and types for the PSRAM QPI responder.
//               Holds the recognised opcodes, the responder state encoding
//               and the width of the link-level address.
// Revision    : 1.0 - initial release
// ============================================================================
package psram_pkg;

  // Opcodes understood by the responder
  localparam logic [7:0] c_op_qpi_en  = 8'h35;  // enter QPI (no-op once in QPI)
  localparam logic [7:0] c_op_qpi_ex  = 8'hF5;  // exit QPI
  localparam logic [7:0] c_op_read    = 8'hEB;  // quad read
  localparam logic [7:0] c_op_write   = 8'h38;  // quad write

  // The link always carries a 24-bit address, sent as 6 nibbles
  localparam int c_link_addr_bits = 24;
  localparam int c_addr_nibbles   = c_link_addr_bits / 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/psram_qpi_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : psram_qpi_responder_if
// Description : PSRAM QPI pin bundle between the memory controller (master)
//               and the device-side responder (slave).
//   psram_cs    controller -> device, chip select, active low
//   psram_sclk  controller -> device, serial clock (clk-domain generated)
//   psram_din   controller -> device, data nibble (bit 0 = SPI serial in)
//   psram_dout  device -> controller, read data nibble
//   psram_oe    device -> controller, 1 = device drives psram_dout
//   qpi_mode    device status, 1 = 4-bit command mode
//   cmd_error   device status, one-clk pulse on unrecognised command
// Revision    : 1.0 - initial release
// ============================================================================
interface psram_qpi_responder_if;
  logic       psram_cs;
  logic       psram_sclk;
  logic [3:0] psram_din;
  logic [3:0] psram_dout;
  logic       psram_oe;
  logic       qpi_mode;
  logic       cmd_error;

  modport master (
    output psram_cs, psram_sclk, psram_din,
    input  psram_dout, psram_oe, qpi_mode, cmd_error
  );

  modport slave (
    input  psram_cs, psram_sclk, psram_din,
    output psram_dout, psram_oe, qpi_mode, cmd_error
  );
endinterface
`default_nettype wire

// File: rtl/psram_resp_mem.sv
`default_nettype none
// ============================================================================
// Module      : psram_resp_mem
// Description : Single-port byte array backing the responder. Synchronous
//               write, asynchronous read. Contents are not reset.
//   clk       system clock
//   i_we      write enable
//   i_addr    byte address (ADDR_WIDTH bits)
//   i_wdata   write byte
//   o_rdata   read byte at i_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module psram_resp_mem #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_wdata,
  output logic [7:0]            o_rdata
);

  logic [7:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/psram_qpi_responder.sv
`default_nettype none
// ============================================================================
// Module      : psram_qpi_responder
// Description : Device-side PSRAM responder for the QPI link. Samples the
//               controller's CS/SCLK/data in the clk domain, decodes
//               SPI/QPI commands and serves quad reads and writes from an
//               internal byte array.
//   clk      system clock, all logic on posedge
//   reset    asynchronous active-high reset
//   bus      psram_qpi_responder_if.slave pin bundle
// Parameters:
//   ADDR_WIDTH   address bits backed by storage (2^ADDR_WIDTH bytes)
//   WAIT_CYCLES  SCLK rises between last address nibble and read data
// Build option:
//   PSRAM_RESP_SPI_EN  when defined the device powers up in SPI mode and
//                      accepts 0x35 / 0xF5 to enter / leave QPI. Otherwise
//                      the device is permanently in QPI mode.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_qpi_responder
  import psram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  psram_qpi_responder_if.slave   bus
);

  localparam int c_ww = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [c_ww-1:0] c_wait_last = c_ww'(WAIT_CYCLES - 1);
  localparam logic [2:0]      c_addr_last = 3'(c_addr_nibbles - 1);

  resp_state_t           r_state;
  logic                  r_sclk_q;
  logic [2:0]            r_cnt;        // command bit / nibble and address nibble counter
  logic [c_ww-1:0]       r_wait;
  logic [3:0]            r_cmd_hi;     // first QPI command nibble
  logic                  r_is_read;
  logic                  r_nib_lo;     // 0 = next data nibble is the high one
  logic [3:0]            r_whi;        // pending high nibble of a write byte
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_dout;
  logic                  r_oe;
  logic                  r_err;

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_qpi;
  logic [7:0]            w_qpi_cmd;
  logic [7:0]            w_rdata;
  logic                  w_we;

  assign w_rise    = bus.psram_sclk & ~r_sclk_q;
  assign w_fall    = ~bus.psram_sclk & r_sclk_q;
  assign w_qpi_cmd = {r_cmd_hi, bus.psram_din};

  // A write lands on the rise carrying the low nibble; CS high blocks it.
  assign w_we = (r_state == ST_WDATA) && w_rise && r_nib_lo && !bus.psram_cs;

`ifdef PSRAM_RESP_SPI_EN
  logic       r_qpi;
  logic [6:0] r_spi_sh;
  logic [7:0] w_spi_cmd;
  assign w_spi_cmd = {r_spi_sh, bus.psram_din[0]};
  assign w_qpi     = r_qpi;
`else
  assign w_qpi     = 1'b1;
`endif

  psram_resp_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata ({r_whi, bus.psram_din}),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_sclk_q  <= 1'b0;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_cmd_hi  <= '0;
      r_is_read <= 1'b0;
      r_nib_lo  <= 1'b0;
      r_whi     <= '0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_oe      <= 1'b0;
      r_err     <= 1'b0;
`ifdef PSRAM_RESP_SPI_EN
      r_qpi     <= 1'b0;
      r_spi_sh  <= '0;
`endif
    end else begin
      r_sclk_q <= bus.psram_sclk;
      r_err    <= 1'b0;

      if (bus.psram_cs) begin
        // Deselect wins over any SCLK edge in the same clk.
        r_state  <= ST_IDLE;
        r_oe     <= 1'b0;
        r_cnt    <= '0;
        r_wait   <= '0;
        r_nib_lo <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_CMD;
            r_cnt   <= '0;
          end

          ST_CMD: begin
            if (w_rise) begin
`ifdef PSRAM_RESP_SPI_EN
              if (!r_qpi) begin
                r_spi_sh <= w_spi_cmd[6:0];
                r_cnt    <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                  r_state <= ST_IGNORE;
                  if (w_spi_cmd == c_op_qpi_en) begin
                    r_qpi <= 1'b1;
                  end else begin
                    r_err <= 1'b1;
                  end
                end
              end else
`endif
              begin
                r_cmd_hi <= bus.psram_din;
                r_cnt    <= r_cnt + 3'd1;
                if (r_cnt[0]) begin
                  r_cnt <= '0;
                  case (w_qpi_cmd)
                    c_op_read: begin
                      r_state   <= ST_ADDR;
                      r_is_read <= 1'b1;
                    end
                    c_op_write: begin
                      r_state   <= ST_ADDR;
                      r_is_read <= 1'b0;
                    end
                    c_op_qpi_en: r_state <= ST_IGNORE;
`ifdef PSRAM_RESP_SPI_EN
                    c_op_qpi_ex: begin
                      r_qpi   <= 1'b0;
                      r_state <= ST_IGNORE;
                    end
`endif
                    default: begin
                      r_err   <= 1'b1;
                      r_state <= ST_IGNORE;
                    end
                  endcase
                end
              end
            end
          end

          ST_ADDR: begin
            if (w_rise) begin
              // Upper link address bits shift out of the top: aliasing.
              r_addr <= ADDR_WIDTH'({r_addr, bus.psram_din});
              r_cnt  <= r_cnt + 3'd1;
              if (r_cnt == c_addr_last) begin
                r_cnt    <= '0;
                r_wait   <= '0;
                r_nib_lo <= 1'b0;
                r_state  <= r_is_read ? ST_WAIT : ST_WDATA;
              end
            end
          end

          ST_WAIT: begin
            if (w_rise) begin
              if (r_wait == c_wait_last) begin
                r_state <= ST_RDATA;
              end else begin
                r_wait <= r_wait + 1'b1;
              end
            end
          end

          ST_RDATA: begin
            // First fall here precedes the first data rise; oe goes up with it.
            if (w_fall) begin
              r_oe     <= 1'b1;
              r_nib_lo <= ~r_nib_lo;
              if (!r_nib_lo) begin
                r_dout <= w_rdata[7:4];
              end else begin
                r_dout <= w_rdata[3:0];
                r_addr <= r_addr + 1'b1;
              end
            end
          end

          ST_WDATA: begin
            if (w_rise) begin
              r_nib_lo <= ~r_nib_lo;
              if (!r_nib_lo) begin
                r_whi <= bus.psram_din;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
          end

          ST_IGNORE: begin
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.psram_dout = r_dout;
  assign bus.psram_oe   = r_oe;
  assign bus.qpi_mode   = w_qpi;
  assign bus.cmd_error  = r_err;

endmodule
`default_nettype wire
